// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, next-PC select and RUN/HALT/FAULT run control
// in front of a word-addressed instruction ROM, plus a retired-fetch counter.
module pc_fetch_unit #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter bit                HALT_EN   = 1'b1,
  parameter logic [DATA_W-1:0] HALT_WORD = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [DATA_W-1:0] instr,
  input  logic              branch_taken,
  input  logic              jump,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_plus4,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int unsigned SEXT_W = DATA_W - 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] br_off;
  logic [DATA_W-1:0] br_tgt;
  logic [DATA_W-1:0] j_tgt;
  logic [DATA_W-1:0] next_pc;
  logic              is_term;
  logic              out_of_range;

  assign imem_addr = pc[ADDR_W+1:2];
  assign pc_plus4  = pc + DATA_W'(4);

  // Branch/jump target generation and next-PC select (jump beats branch).
  always_comb begin
    br_off  = '0;
    br_tgt  = '0;
    j_tgt   = '0;
    next_pc = pc_plus4;
    br_off  = {{SEXT_W{instr[15]}}, instr[15:0]} << 2;
    br_tgt  = pc_plus4 + br_off;
    j_tgt   = {pc_plus4[DATA_W-1:28], instr[25:0], 2'b00};
    if (jump) begin
      next_pc = j_tgt;
    end else if (branch_taken) begin
      next_pc = br_tgt;
    end
  end

  // Terminator word detection and ROM range check on the selected target.
  assign is_term      = HALT_EN && (instr == HALT_WORD);
  assign out_of_range = |next_pc[DATA_W-1:ADDR_W+2];

  // Run-control FSM with registered state decodes, PC and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      instr_count <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!stall) begin
            if (is_term) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else if (out_of_range) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              pc <= next_pc;
              if (instr_count != {CNT_W{1'b1}}) begin
                instr_count <= instr_count + CNT_W'(1);
              end
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state  <= ST_FAULT;
          fault  <= 1'b1;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] instr;
  logic        branch_taken;
  logic        jump;
  logic [7:0]  imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rom [16];
  int          visits;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .instr        (instr),
    .branch_taken (branch_taken),
    .jump         (jump),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .halted       (halted),
    .fault        (fault),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] i, input logic br, input logic j, input logic s);
    instr        = i;
    branch_taken = br;
    jump         = j;
    stall        = s;
  endtask

  initial begin
    rst = 1'b1;
    set_in(32'h0, 1'b0, 1'b0, 1'b0);

    // 1: reset state, then three sequential fetches
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_count", 32'(instr_count), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    rst = 1'b0;
    set_in(32'h20080003, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("seq_pc", pc, 32'h0C);
    check("seq_count", 32'(instr_count), 32'd3);

    // 2: taken branch from 0x10 to 0x20, then jump back and not-taken branch
    tick();
    check("pc_at_10", pc, 32'h10);
    set_in(32'h12000003, 1'b1, 1'b0, 1'b0);
    tick();
    check("br_taken_pc", pc, 32'h20);
    check("br_taken_addr", 32'(imem_addr), 32'h8);
    set_in(32'h08000004, 1'b0, 1'b1, 1'b0);
    tick();
    check("jump_back_pc", pc, 32'h10);
    set_in(32'h12000003, 1'b0, 1'b0, 1'b0);
    tick();
    check("br_not_taken_pc", pc, 32'h14);
    check("br_count", 32'(instr_count), 32'd7);

    // 3: jump wins over branch at 0x1C
    set_in(32'h20080003, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("pc_at_1c", pc, 32'h1C);
    set_in(32'h08000004, 1'b1, 1'b1, 1'b0);
    tick();
    check("jump_prio_pc", pc, 32'h10);
    check("jump_prio_count", 32'(instr_count), 32'd10);

    // backward branch with negative offset: 0x14 - 0x10 = 0x04
    set_in(32'h1000FFFC, 1'b1, 1'b0, 1'b0);
    tick();
    check("br_neg_pc", pc, 32'h04);

    // 4: terminator held off by stall, then halt and absorb
    set_in(32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    check("stall_halted", 32'(halted), 32'h0);
    check("stall_pc", pc, 32'h04);
    check("stall_count", 32'(instr_count), 32'd11);
    set_in(32'h08000004, 1'b0, 1'b1, 1'b1);
    tick();
    check("stall_jump_pc", pc, 32'h04);
    set_in(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_fault", 32'(fault), 32'h0);
    check("halt_pc", pc, 32'h04);
    check("halt_count", 32'(instr_count), 32'd11);
    set_in(32'h08000004, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    check("halt_abs_pc", pc, 32'h04);
    check("halt_abs_halted", 32'(halted), 32'h1);
    check("halt_abs_count", 32'(instr_count), 32'd11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("halt_rst_halted", 32'(halted), 32'h0);
    check("halt_rst_pc", pc, 32'h0);
    check("halt_rst_count", 32'(instr_count), 32'h0);

    // 5: jump to 0x400 is out of range -> fault, absorbing, cleared by reset
    set_in(32'h08000100, 1'b0, 1'b1, 1'b0);
    tick();
    check("fault_fault", 32'(fault), 32'h1);
    check("fault_halted", 32'(halted), 32'h0);
    check("fault_pc", pc, 32'h0);
    check("fault_count", 32'(instr_count), 32'h0);
    set_in(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check("fault_abs_halted", 32'(halted), 32'h0);
    check("fault_abs_fault", 32'(fault), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("fault_rst_fault", 32'(fault), 32'h0);
    check("fault_rst_pc", pc, 32'h0);

    // range boundary: 0x3FC legal, sequential step to 0x400 faults
    set_in(32'h080000FF, 1'b0, 1'b1, 1'b0);
    tick();
    check("top_pc", pc, 32'h3FC);
    check("top_addr", 32'(imem_addr), 32'hFF);
    check("top_fault", 32'(fault), 32'h0);
    set_in(32'h20080003, 1'b0, 1'b0, 1'b0);
    tick();
    check("wrap_fault", 32'(fault), 32'h1);
    check("wrap_pc", pc, 32'h3FC);
    check("wrap_count", 32'(instr_count), 32'd1);

    // terminator has priority over range check at 0x3FC
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(32'h080000FF, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check("prio_halted", 32'(halted), 32'h1);
    check("prio_fault", 32'(fault), 32'h0);

    // 6: full program with a loop 0x10..0x1C taken twice, ends at padding 0x24
    rom[0]  = 32'h20080003;
    rom[1]  = 32'h20090000;
    rom[2]  = 32'h200A0001;
    rom[3]  = 32'h200B0002;
    rom[4]  = 32'h01294820;
    rom[5]  = 32'h2108FFFF;
    rom[6]  = 32'h00000020;
    rom[7]  = 32'h1500FFFC;
    rom[8]  = 32'h200C0007;
    for (int k = 9; k < 16; k++) rom[k] = 32'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    visits = 0;
    for (int cyc = 0; cyc < 100 && !halted; cyc++) begin
      instr        = (imem_addr < 8'd16) ? rom[imem_addr[3:0]] : 32'h0;
      jump         = 1'b0;
      stall        = 1'b0;
      branch_taken = (imem_addr == 8'd7) && (visits < 2);
      if (branch_taken) visits++;
      tick();
    end
    check("prog_halted", 32'(halted), 32'h1);
    check("prog_fault", 32'(fault), 32'h0);
    check("prog_pc", pc, 32'h24);
    check("prog_count", 32'(instr_count), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
